// File: rtl/imem_port_arbiter_pkg.sv
// Shared definitions for the instruction-memory port arbiter and its neighbours
// (decode stage reuses NOP; data-memory side reuses the address check widths).
package imem_port_arbiter_pkg;
    localparam int DEPTH = 1024;
    localparam int AW = 10;
    localparam logic [31:0] NOP = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;
endpackage

// File: rtl/imem_port_arbiter_if.sv
// Bus bundle between the requesters (fetch, loader), the arbiter and the memory array.
interface imem_port_arbiter_if;
    import imem_port_arbiter_pkg::*;

    // Handshake: a requester holds *_req with its address/data stable; the arbiter
    // answers with a single-cycle *_gnt in that same cycle when the access is taken.
    // Read results appear registered one cycle after the grant.
    logic          fetch_req;
    logic [31:0]   fetch_addr;
    logic          fetch_gnt;
    logic          fetch_valid;
    logic [31:0]   fetch_instr;
    logic          fetch_err;
    logic          flush;
    logic          load_req;
    logic          load_we;
    logic [AW-1:0] load_addr;
    logic [31:0]   load_wdata;
    logic          load_gnt;
    logic [31:0]   load_rdata;
    logic          load_done;
    logic          halt_req;
    logic          halted;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    modport master (
        output fetch_req, fetch_addr, flush, load_req, load_we, load_addr, load_wdata,
               load_done, halt_req, mem_rdata,
        input  fetch_gnt, fetch_valid, fetch_instr, fetch_err, load_gnt, load_rdata,
               halted, mem_addr, mem_we, mem_wdata
    );

    modport slave (
        input  fetch_req, fetch_addr, flush, load_req, load_we, load_addr, load_wdata,
               load_done, halt_req, mem_rdata,
        output fetch_gnt, fetch_valid, fetch_instr, fetch_err, load_gnt, load_rdata,
               halted, mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/imem_addr_check.sv
// Byte address to word address conversion with alignment and range check.
module imem_addr_check
    import imem_port_arbiter_pkg::*;
#(
    parameter int AW_P = AW
) (
    input  logic [31:0]     addr,
    output logic [AW_P-1:0] word,
    output logic            err
);
    assign word = addr[AW_P+1:2];
    assign err  = (addr[1:0] != 2'b00) | (addr[31:AW_P+2] != '0);
endmodule

// File: rtl/imem_port_arbiter.sv
// Shares the single instruction-memory port between fetch and the program loader,
// sequencing boot (loader first) and halt-driven hand-back to the loader.
module imem_port_arbiter
    import imem_port_arbiter_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    imem_port_arbiter_if.slave  bus,
    output state_t              dbg_state
);
    state_t        state, state_nxt;
    logic [AW-1:0] fetch_word;
    logic          fetch_bad;
    logic [AW-1:0] addr_q;
    logic          pending_q;
    logic          fetch_gnt_c, load_gnt_c, mem_we_c;
    logic [AW-1:0] mem_addr_c;
    logic          fetch_valid_q, fetch_err_q;
    logic [31:0]   fetch_instr_q, load_rdata_q;

    imem_addr_check #(.AW_P(AW)) u_check (
        .addr (bus.fetch_addr),
        .word (fetch_word),
        .err  (fetch_bad)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_LOAD;
            addr_q    <= '0;
            pending_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            addr_q    <= mem_addr_c;
            pending_q <= fetch_gnt_c;
        end
    end

    // A bad fetch address never reaches the array: mem_addr keeps its last value.
    always_comb begin
        state_nxt   = state;
        fetch_gnt_c = 1'b0;
        load_gnt_c  = 1'b0;
        mem_we_c    = 1'b0;
        mem_addr_c  = addr_q;
        case (state)
            ST_LOAD: begin
                load_gnt_c = bus.load_req;
                mem_addr_c = bus.load_addr;
                mem_we_c   = bus.load_req & bus.load_we;
                if (bus.load_done) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                fetch_gnt_c = bus.fetch_req & ~bus.halt_req;
                if (!fetch_bad) mem_addr_c = fetch_word;
                if (bus.halt_req) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!pending_q) state_nxt = ST_LOAD;
            end
            default: state_nxt = ST_LOAD;
        endcase
        if (!rst) begin
            fetch_gnt_c = 1'b0;
            load_gnt_c  = 1'b0;
            mem_we_c    = 1'b0;
            mem_addr_c  = '0;
        end
    end

    // Flush wins over any response, including one granted in the flush cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_valid_q <= 1'b0;
            fetch_err_q   <= 1'b0;
            fetch_instr_q <= NOP;
            load_rdata_q  <= '0;
        end else begin
            fetch_valid_q <= fetch_gnt_c & ~bus.flush;
            fetch_err_q   <= fetch_gnt_c & ~bus.flush & fetch_bad;
            if (bus.flush)       fetch_instr_q <= NOP;
            else if (fetch_gnt_c) fetch_instr_q <= fetch_bad ? NOP : bus.mem_rdata;
            if (load_gnt_c & ~bus.load_we) load_rdata_q <= bus.mem_rdata;
        end
    end

    assign bus.fetch_gnt   = fetch_gnt_c;
    assign bus.load_gnt    = load_gnt_c;
    assign bus.mem_we      = mem_we_c;
    assign bus.mem_addr    = mem_addr_c;
    assign bus.mem_wdata   = bus.load_wdata;
    assign bus.fetch_valid = fetch_valid_q;
    assign bus.fetch_err   = fetch_err_q;
    assign bus.fetch_instr = fetch_instr_q;
    assign bus.load_rdata  = load_rdata_q;
    assign bus.halted      = ~rst | (state == ST_LOAD);
    assign dbg_state       = state;
endmodule

// File: tb/tb_imem_port_arbiter.sv
// Bench for imem_port_arbiter: directed sequences, an address table and random traffic
// checked every cycle against a behavioural model of the port sharing rules.
module tb_imem_port_arbiter;
    import imem_port_arbiter_pkg::*;

    logic   clk = 1'b0;
    logic   rst;
    state_t dbg_state;
    int     checks = 0;
    int     errors = 0;

    imem_port_arbiter_if bus();

    imem_port_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    // Instruction memory array driven by the DUT's port.
    logic [31:0] mem [DEPTH] = '{default: 32'h0};
    assign bus.mem_rdata = mem[bus.mem_addr];
    always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;

    // Behavioural model: mode 0 = loader owns port, 1 = fetch runs, 2 = handing back.
    int          m_mode = 0;
    bit          m_init = 0;
    logic [31:0] m_rdata = '0;
    logic [31:0] shadow [DEPTH] = '{default: 32'h0};
    logic [32:0] exp_q[$];
    bit          e_fg, e_lg;

    typedef struct {
        logic [31:0] addr;
        logic        err;
        logic [31:0] instr;
    } fvec_t;
    fvec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic bit addr_bad(input logic [31:0] a);
        return (a % 4 != 0) || (a >= 32'(4 * DEPTH));
    endfunction

    task automatic model_check();
        logic [AW-1:0] w;
        if (!rst) begin
            e_fg = 0;
            e_lg = 0;
            chk("rst_fetch_gnt", bus.fetch_gnt, 0);
            chk("rst_load_gnt", bus.load_gnt, 0);
            chk("rst_mem_we", bus.mem_we, 0);
            chk("rst_halted", bus.halted, 1);
            chk("rst_mem_addr", bus.mem_addr, 0);
        end else begin
            e_fg = (m_mode == 1) && bus.fetch_req && !bus.halt_req;
            e_lg = (m_mode == 0) && bus.load_req;
            chk("fetch_gnt", bus.fetch_gnt, e_fg);
            chk("load_gnt", bus.load_gnt, e_lg);
            chk("mem_we", bus.mem_we, e_lg && bus.load_we);
            chk("halted", bus.halted, m_mode == 0);
            if (e_lg) chk("mem_addr_load", bus.mem_addr, bus.load_addr);
            if (e_lg && bus.load_we) chk("mem_wdata", bus.mem_wdata, bus.load_wdata);
            if (e_fg && !addr_bad(bus.fetch_addr)) begin
                w = bus.fetch_addr[AW+1:2];
                chk("mem_addr_fetch", bus.mem_addr, w);
            end
        end
        if (m_init) begin
            chk("fetch_valid", bus.fetch_valid, exp_q.size() != 0);
            if (exp_q.size() != 0) begin
                chk("fetch_err", bus.fetch_err, exp_q[0][32]);
                chk("fetch_instr", bus.fetch_instr, exp_q[0][31:0]);
            end else begin
                chk("fetch_err_idle", bus.fetch_err, 0);
            end
            chk("load_rdata", bus.load_rdata, m_rdata);
        end
    endtask

    task automatic model_step();
        logic [AW-1:0] w;
        if (!rst) begin
            m_mode = 0;
            exp_q.delete();
            m_rdata = '0;
            m_init = 1;
            return;
        end
        exp_q.delete();
        if (e_fg && !bus.flush) begin
            w = bus.fetch_addr[AW+1:2];
            if (addr_bad(bus.fetch_addr)) exp_q.push_back({1'b1, NOP});
            else                          exp_q.push_back({1'b0, shadow[w]});
        end
        if (e_lg && !bus.load_we) m_rdata = shadow[bus.load_addr];
        if (e_lg && bus.load_we)  shadow[bus.load_addr] = bus.load_wdata;
        case (m_mode)
            0: if (bus.load_done) m_mode = 1;
            1: if (bus.halt_req) m_mode = 2;
            default: m_mode = 0;
        endcase
    endtask

    // Inputs are set after a rising edge; outputs are sampled on the falling edge.
    task automatic cycle();
        @(negedge clk);
        model_check();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.fetch_req = 0; bus.fetch_addr = '0; bus.flush = 0;
        bus.load_req = 0; bus.load_we = 0; bus.load_addr = '0; bus.load_wdata = '0;
        bus.load_done = 0; bus.halt_req = 0;
    endtask

    initial begin
        tbl[0] = '{32'h0000_0000, 1'b0, 32'h1234_5678};
        tbl[1] = '{32'h0000_0004, 1'b0, 32'h0000_0020};
        tbl[2] = '{32'h0000_0002, 1'b1, NOP};
        tbl[3] = '{32'h0000_1000, 1'b1, NOP};
        tbl[4] = '{32'h0000_0008, 1'b0, 32'h0000_0000};
        tbl[5] = '{32'h0000_0003, 1'b1, NOP};
        tbl[6] = '{32'h0000_0FFC, 1'b0, 32'h0000_0000};
        tbl[7] = '{32'h8000_0000, 1'b1, NOP};
        tbl[8] = '{32'h0000_0FFE, 1'b1, NOP};
        tbl[9] = '{32'h0000_0001, 1'b1, NOP};

        // Boot: reset, loader writes two words, then hands over to fetch.
        rst = 0;
        idle();
        cycle();
        cycle();
        chk("reset_fetch_valid", bus.fetch_valid, 0);
        chk("reset_fetch_instr", bus.fetch_instr, NOP);
        chk("reset_load_rdata", bus.load_rdata, 0);
        chk("reset_state", dbg_state, ST_LOAD);
        chk("reset_halted", bus.halted, 1);
        rst = 1;
        bus.fetch_req = 1;
        bus.load_req = 1; bus.load_we = 1; bus.load_addr = 0; bus.load_wdata = 32'h1234_5678;
        cycle();
        chk("ignore_fetch_in_load", bus.fetch_gnt, 0);
        bus.load_addr = 1; bus.load_wdata = 32'h0000_0020;
        cycle();
        bus.fetch_req = 0; bus.load_req = 0; bus.load_we = 0; bus.load_done = 1;
        cycle();
        chk("boot_halted_fell", bus.halted, 0);
        bus.load_done = 0;
        bus.fetch_req = 1; bus.fetch_addr = 32'h0;
        cycle();
        chk("boot_valid0", bus.fetch_valid, 1);
        chk("boot_instr0", bus.fetch_instr, 32'h1234_5678);
        bus.fetch_addr = 32'h4;
        cycle();
        chk("boot_valid1", bus.fetch_valid, 1);
        chk("boot_instr1", bus.fetch_instr, 32'h0000_0020);
        idle();
        cycle();
        chk("boot_valid_end", bus.fetch_valid, 0);

        // Address table: alignment and range checks.
        for (int i = 0; i < 10; i++) begin
            bus.fetch_req = 1;
            bus.fetch_addr = tbl[i].addr;
            cycle();
            chk("tbl_valid", bus.fetch_valid, 1);
            chk("tbl_err", bus.fetch_err, tbl[i].err);
            chk("tbl_instr", bus.fetch_instr, tbl[i].instr);
            chk("tbl_mem_we", bus.mem_we, 0);
        end
        idle();
        cycle();

        // Flush kills the response of a same-cycle grant; next grant is delivered.
        bus.fetch_req = 1; bus.fetch_addr = 32'h0; bus.flush = 1;
        cycle();
        chk("flush_suppress", bus.fetch_valid, 0);
        bus.flush = 0; bus.fetch_addr = 32'h4;
        cycle();
        chk("flush_next_valid", bus.fetch_valid, 1);
        chk("flush_next_instr", bus.fetch_instr, 32'h0000_0020);
        idle();

        // Loader is ignored while fetch owns the port.
        bus.load_req = 1; bus.load_we = 1; bus.load_addr = 0; bus.load_wdata = 32'hDEAD_BEEF;
        #1;
        chk("ignore_load_gnt", bus.load_gnt, 0);
        chk("ignore_load_we", bus.mem_we, 0);
        cycle();
        idle();
        bus.fetch_req = 1; bus.fetch_addr = 32'h0;
        cycle();
        chk("ignore_mem_kept", bus.fetch_instr, 32'h1234_5678);

        // Halt handshake with a fetch in flight, then loader write and readback.
        bus.halt_req = 1;
        #1;
        chk("halt_blocks_gnt", bus.fetch_gnt, 0);
        chk("halt_pending_valid", bus.fetch_valid, 1);
        chk("halt_pending_instr", bus.fetch_instr, 32'h1234_5678);
        cycle();
        chk("halt_no_new_valid", bus.fetch_valid, 0);
        idle();
        cycle();
        chk("halt_halted", bus.halted, 1);
        bus.halt_req = 1;
        bus.load_req = 1; bus.load_we = 1; bus.load_addr = 5; bus.load_wdata = 32'hA5A5_5A5A;
        cycle();
        bus.load_we = 0;
        cycle();
        chk("readback", bus.load_rdata, 32'hA5A5_5A5A);
        chk("halt_ignored_in_load", bus.halted, 1);
        idle();
        bus.load_done = 1;
        cycle();

        // Reset in the middle of a fetch stream.
        idle();
        bus.fetch_req = 1; bus.fetch_addr = 32'h4;
        cycle();
        cycle();
        rst = 0;
        cycle();
        chk("midrst_valid", bus.fetch_valid, 0);
        chk("midrst_instr", bus.fetch_instr, NOP);
        chk("midrst_halted", bus.halted, 1);
        chk("midrst_state", dbg_state, ST_LOAD);
        rst = 1;
        idle();
        cycle();

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            int r;
            rst = ($urandom_range(0, 199) != 0);
            bus.fetch_req = ($urandom_range(0, 9) < 7);
            r = $urandom_range(0, 9);
            if (r < 7)       bus.fetch_addr = 32'($urandom_range(0, 15)) * 4;
            else if (r == 7) bus.fetch_addr = $urandom;
            else if (r == 8) bus.fetch_addr = 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(1, 3));
            else             bus.fetch_addr = 32'h1000 + 32'($urandom_range(0, 15)) * 4;
            bus.flush = ($urandom_range(0, 9) == 0);
            bus.halt_req = ($urandom_range(0, 29) == 0);
            bus.load_req = ($urandom_range(0, 9) < 6);
            bus.load_we = $urandom_range(0, 1) != 0;
            bus.load_addr = AW'($urandom_range(0, 15));
            bus.load_wdata = $urandom;
            bus.load_done = ($urandom_range(0, 19) == 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
